hub75_scan_engine: RTL
======================

Name: hub75_scan_engine

Overview:
- Row scan and bit-plane sequencer that drives the HUB75 PHY's `phy_*` inputs (address, data, clk, le, blank).
- Per command: reads one row of pixels from a 1-cycle-latency line buffer, extracts the requested bit plane and shifts it out.
- Then blanks, latches, updates the row address and holds the panel lit for a binary-weighted (BCM) on-time.
- Shifting of the next row overlaps the current row's on-time.

Parameters:
- N_BANKS, 2, number of panel banks (upper/lower halves).
- N_ROWS, 32, rows per bank.
- N_COLS, 64, pixels shifted per row.
- N_CHANS, 3, colour channels per bank.
- BITDEPTH, 8, bit planes per channel.
- LOG_N_ROWS, $clog2(N_ROWS), auto-set.
- LOG_N_COLS, $clog2(N_COLS), auto-set.
- LOG_BITDEPTH, $clog2(BITDEPTH), auto-set.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- ctrl_go  in  1  start a row/plane; accepted only when ctrl_rdy=1.
- ctrl_row  in  LOG_N_ROWS  row address; sampled on accept.
- ctrl_plane  in  LOG_BITDEPTH  bit plane; sampled on accept.
- ctrl_rdy  out  1  engine idle, will accept ctrl_go.
- cfg_tick  in  16  base on-time in clk cycles for plane 0; sampled when the timer loads.
- buf_rd_addr  out  LOG_N_COLS  line-buffer column address.
- buf_rd_data  in  N_BANKS*N_CHANS*BITDEPTH  pixel word; valid 1 cycle after address.
- phy_addr  out  LOG_N_ROWS  row address to PHY.
- phy_data  out  N_BANKS*N_CHANS  shift data to PHY.
- phy_clk  out  1  shift strobe, one cycle high per column.
- phy_le  out  1  latch enable.
- phy_blank  out  1  output blanking; 1 = dark.

Behaviour:
- All outputs are registered.
- Reset values: ctrl_rdy=1, phy_blank=1, all other outputs 0. The on-timer clears and the FSM goes to IDLE.
- A reset mid-operation aborts immediately with the same values, including mid-shift and mid-on-time.
- FSM states: IDLE, SHIFT, DRAIN, WAIT, BLANK, LATCH, ADDR.
- IDLE:
  - ctrl_rdy=1.
  - ctrl_go=1 latches row and plane, drops ctrl_rdy and enters SHIFT on the next cycle.
  - ctrl_go while ctrl_rdy=0 is ignored, with no queuing.
- SHIFT:
  - Exactly N_COLS cycles; buf_rd_addr = 0, 1, …, N_COLS-1.
  - The column counter wraps to 0 on exit.
- Bit extraction: for the data returned from address k, two cycles after the address is presented:
  - phy_data[b*N_CHANS+c] = buf_rd_data[(b*N_CHANS+c)*BITDEPTH + plane].
  - phy_clk=1 in the same cycle.
  - phy_clk is therefore high for N_COLS consecutive cycles. The first high cycle is 2 cycles after buf_rd_addr=0.
  - phy_data=0 whenever phy_clk=0.
- DRAIN: 2 cycles, flushing the pipeline.
- WAIT: stay until the on-timer is 0; then go to BLANK.
- BLANK: phy_blank=1, 1 cycle.
- LATCH: phy_le=1 for exactly 1 cycle, with phy_blank=1.
- ADDR:
  - phy_addr <= latched row; phy_le=0; phy_blank=1.
  - Load the on-timer with cfg_tick << plane (width 16+BITDEPTH, no overflow).
  - Then return to IDLE (ctrl_rdy=1).
- On-timer:
  - Decrements once per cycle while nonzero.
  - phy_blank=0 exactly while the timer is nonzero and the FSM is not in BLANK/LATCH/ADDR.
  - Lit duration is exactly cfg_tick<<plane cycles, starting the cycle after ADDR.
- cfg_tick=0: the timer stays 0, phy_blank never deasserts, and the sequence still completes (latch and address update).
- The timer runs independently of the FSM: a new command may shift while the previous row is lit. The WAIT state guarantees the latch never occurs while lit.
- phy_addr changes only in ADDR; phy_le and phy_addr never change while phy_blank=0.

Test Plan:
- Reset: hold rst 3 cycles mid-SHIFT → next cycle ctrl_rdy=1, phy_blank=1, phy_clk=0, phy_le=0, phy_addr=0, phy_data=0.
- Single row (N_COLS=4, plane=0, cfg_tick=10, row=5), buffer word at col k = 0x…k pattern → 4 phy_clk pulses starting 2 cycles after buf_rd_addr=0, with phy_data equal to bit 0 of each channel field. Then the following hold:
  - phy_le is one pulse.
  - phy_addr=5 after ADDR.
  - phy_blank=0 for exactly 10 cycles.
- Plane weighting: plane=3, cfg_tick=10 → phy_blank low for exactly 80 cycles; with BITDEPTH=8 and plane=7, cfg_tick=0xFFFF → 0xFFFF<<7 counted without truncation.
- Overlap: issue a second ctrl_go (row=6) as soon as ctrl_rdy rises with the first on-time=200 → the second row's shifting completes during the lit period. Required: LATCH for row 6 occurs exactly on the cycle after the timer reaches 0, and phy_le never coincides with phy_blank=0.
- Back-pressure: pulse ctrl_go every cycle during SHIFT/WAIT → ignored; exactly one row sequence runs per accepted command.
- cfg_tick=0 → full shift, latch and address update occur; phy_blank stays 1 throughout; ctrl_rdy returns 1.

Source files
------------

// File: rtl/hub75_scan_engine_if.sv
// Command, line-buffer and PHY signal bundle of the HUB75 scan engine.
interface hub75_scan_engine_if #(
    parameter int N_BANKS      = 2,
    parameter int N_ROWS       = 32,
    parameter int N_COLS       = 64,
    parameter int N_CHANS      = 3,
    parameter int BITDEPTH     = 8,
    parameter int LOG_N_ROWS   = $clog2(N_ROWS),
    parameter int LOG_N_COLS   = $clog2(N_COLS),
    parameter int LOG_BITDEPTH = $clog2(BITDEPTH)
);
    logic                                ctrl_go;
    logic [LOG_N_ROWS-1:0]               ctrl_row;
    logic [LOG_BITDEPTH-1:0]             ctrl_plane;
    logic                                ctrl_rdy;
    logic [15:0]                         cfg_tick;
    logic [LOG_N_COLS-1:0]               buf_rd_addr;
    logic [N_BANKS*N_CHANS*BITDEPTH-1:0] buf_rd_data;
    logic [LOG_N_ROWS-1:0]               phy_addr;
    logic [N_BANKS*N_CHANS-1:0]          phy_data;
    logic                                phy_clk;
    logic                                phy_le;
    logic                                phy_blank;

    modport master (
        output ctrl_go, ctrl_row, ctrl_plane, cfg_tick, buf_rd_data,
        input  ctrl_rdy, buf_rd_addr,
        input  phy_addr, phy_data, phy_clk, phy_le, phy_blank
    );

    modport slave (
        input  ctrl_go, ctrl_row, ctrl_plane, cfg_tick, buf_rd_data,
        output ctrl_rdy, buf_rd_addr,
        output phy_addr, phy_data, phy_clk, phy_le, phy_blank
    );
endinterface

// File: rtl/hub75_scan_engine.sv
// HUB75 row scan / bit-plane sequencer: shifts one plane of a row, then
// blanks, latches, readdresses and keeps the row lit for a BCM on-time.
module hub75_scan_engine #(
    parameter int N_BANKS      = 2,
    parameter int N_ROWS       = 32,
    parameter int N_COLS       = 64,
    parameter int N_CHANS      = 3,
    parameter int BITDEPTH     = 8,
    parameter int LOG_N_ROWS   = $clog2(N_ROWS),
    parameter int LOG_N_COLS   = $clog2(N_COLS),
    parameter int LOG_BITDEPTH = $clog2(BITDEPTH)
) (
    input logic clk,
    input logic rst,
    hub75_scan_engine_if.slave bus
);
    localparam int NLANE = N_BANKS * N_CHANS;
    localparam int TW    = 16 + BITDEPTH;
    localparam logic [LOG_N_COLS-1:0] COL_LAST = LOG_N_COLS'(N_COLS - 1);

    typedef enum logic [2:0] {
        IDLE, SHIFT, DRAIN, WAIT, BLANK, LATCH, ADDR
    } state_t;

    state_t                  state, state_nx;
    logic [LOG_N_COLS-1:0]   col, col_nx;
    logic                    dcnt, dcnt_nx;
    logic [LOG_N_ROWS-1:0]   row_q, row_nx;
    logic [LOG_BITDEPTH-1:0] plane_q, plane_nx;
    logic [TW-1:0]           timer, timer_nx;
    logic                    sh_v;
    logic                    rdy_q, rdy_nx;
    logic                    blank_q, blank_nx;
    logic                    le_q, le_nx;
    logic                    clk_q;
    logic [LOG_N_ROWS-1:0]   addr_q, addr_nx;
    logic [NLANE-1:0]        data_q;
    logic [NLANE-1:0]        lane_bit;
    logic                    lit_nx;

    assign bus.ctrl_rdy    = rdy_q;
    assign bus.buf_rd_addr = col;
    assign bus.phy_addr    = addr_q;
    assign bus.phy_data    = data_q;
    assign bus.phy_clk     = clk_q;
    assign bus.phy_le      = le_q;
    assign bus.phy_blank   = blank_q;

    always_comb begin
        lane_bit = '0;
        for (int i = 0; i < NLANE; i++) begin
            logic [BITDEPTH-1:0] f;
            f = bus.buf_rd_data[i*BITDEPTH +: BITDEPTH];
            lane_bit[i] = f[plane_q];
        end
    end

    always_comb begin
        state_nx = state;
        col_nx   = col;
        dcnt_nx  = dcnt;
        row_nx   = row_q;
        plane_nx = plane_q;
        addr_nx  = addr_q;
        timer_nx = (timer != '0) ? timer - 1'b1 : '0;
        unique case (state)
            IDLE: begin
                if (bus.ctrl_go) begin
                    state_nx = SHIFT;
                    row_nx   = bus.ctrl_row;
                    plane_nx = bus.ctrl_plane;
                end
            end
            SHIFT: begin
                col_nx = col + 1'b1;
                if (col == COL_LAST) begin
                    col_nx   = '0;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                dcnt_nx = ~dcnt;
                if (dcnt) state_nx = WAIT;
            end
            // leave as the timer expires so LATCH follows the first dark cycle
            WAIT: begin
                if (timer_nx == '0) state_nx = BLANK;
            end
            BLANK: state_nx = LATCH;
            LATCH: state_nx = ADDR;
            ADDR: begin
                state_nx = IDLE;
                timer_nx = TW'(bus.cfg_tick) << plane_q;
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx == ADDR) addr_nx = row_q;
        rdy_nx   = (state_nx == IDLE);
        le_nx    = (state_nx == LATCH);
        lit_nx   = (timer_nx != '0) &&
                   !(state_nx inside {BLANK, LATCH, ADDR});
        blank_nx = !lit_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            dcnt    <= 1'b0;
            row_q   <= '0;
            plane_q <= '0;
            timer   <= '0;
            sh_v    <= 1'b0;
            rdy_q   <= 1'b1;
            blank_q <= 1'b1;
            le_q    <= 1'b0;
            clk_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            col     <= col_nx;
            dcnt    <= dcnt_nx;
            row_q   <= row_nx;
            plane_q <= plane_nx;
            timer   <= timer_nx;
            sh_v    <= (state == SHIFT);
            rdy_q   <= rdy_nx;
            blank_q <= blank_nx;
            le_q    <= le_nx;
            clk_q   <= sh_v;
            addr_q  <= addr_nx;
            data_q  <= sh_v ? lane_bit : '0;
        end
    end
endmodule
